// File: rtl/svpwm_gate_capture_module.sv
// Measures per-phase high-side on-time of SVPWM gate signals over a fixed window,
// decodes the sector from the duty ordering, and latches a sticky shoot-through fault.
module svpwm_gate_capture_module #(
    parameter int DATA_WIDTH    = 16,
    parameter int WINDOW_CYCLES = 4000
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    input  logic                  capture_enable_in,
    input  logic                  fault_clear_in,
    input  logic                  phase_a_high_side_in,
    input  logic                  phase_a_low_side_in,
    input  logic                  phase_b_high_side_in,
    input  logic                  phase_b_low_side_in,
    input  logic                  phase_c_high_side_in,
    input  logic                  phase_c_low_side_in,
    output logic [DATA_WIDTH-1:0] tcm_a_out,
    output logic [DATA_WIDTH-1:0] tcm_b_out,
    output logic [DATA_WIDTH-1:0] tcm_c_out,
    output logic [2:0]            sector_out,
    output logic                  capture_valid_out,
    output logic                  shoot_through_fault_out,
    output logic                  busy_out
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_REPORT  = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] WIN_LAST = DATA_WIDTH'(WINDOW_CYCLES - 1);

    state_t                state_q;
    logic [5:0]            gate_raw;
    logic [5:0]            sync1_q;
    logic [5:0]            sync2_q;
    logic [DATA_WIDTH-1:0] win_q;
    logic [DATA_WIDTH-1:0] cnt_a_q, cnt_b_q, cnt_c_q;
    logic [DATA_WIDTH-1:0] cnt_a_d, cnt_b_d, cnt_c_d;
    logic [2:0]            sector_d;
    logic                  overlap;
    logic [DATA_WIDTH-1:0] tcm_a_q, tcm_b_q, tcm_c_q;
    logic [2:0]            sector_q;
    logic                  valid_q;
    logic                  busy_q;
    logic                  fault_q;

    // Bit order: {c_lo, c_hi, b_lo, b_hi, a_lo, a_hi}
    assign gate_raw = {phase_c_low_side_in, phase_c_high_side_in,
                       phase_b_low_side_in, phase_b_high_side_in,
                       phase_a_low_side_in, phase_a_high_side_in};

    function automatic logic [DATA_WIDTH-1:0] sat_inc(input logic [DATA_WIDTH-1:0] v,
                                                      input logic                  en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    function automatic logic [2:0] sector_of(input logic [DATA_WIDTH-1:0] a,
                                             input logic [DATA_WIDTH-1:0] b,
                                             input logic [DATA_WIDTH-1:0] c);
        if      (a >= b && b >= c) return 3'd3;
        else if (b >= a && a >= c) return 3'd1;
        else if (b >= c && c >= a) return 3'd5;
        else if (c >= b && b >= a) return 3'd4;
        else if (c >= a && a >= b) return 3'd6;
        else                       return 3'd2;
    endfunction

    // The report loads the counts including the final MEASURE cycle, so decode the next-state values.
    always_comb begin
        cnt_a_d  = sat_inc(cnt_a_q, sync2_q[0]);
        cnt_b_d  = sat_inc(cnt_b_q, sync2_q[2]);
        cnt_c_d  = sat_inc(cnt_c_q, sync2_q[4]);
        sector_d = sector_of(cnt_a_d, cnt_b_d, cnt_c_d);
        overlap  = (sync2_q[0] & sync2_q[1]) | (sync2_q[2] & sync2_q[3]) |
                   (sync2_q[4] & sync2_q[5]);
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= gate_raw;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            win_q    <= '0;
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
            cnt_c_q  <= '0;
            tcm_a_q  <= '0;
            tcm_b_q  <= '0;
            tcm_c_q  <= '0;
            sector_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (capture_enable_in) begin
                        state_q <= ST_MEASURE;
                        busy_q  <= 1'b1;
                        win_q   <= '0;
                        cnt_a_q <= '0;
                        cnt_b_q <= '0;
                        cnt_c_q <= '0;
                    end
                end
                ST_MEASURE: begin
                    if (!capture_enable_in) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_a_q <= cnt_a_d;
                        cnt_b_q <= cnt_b_d;
                        cnt_c_q <= cnt_c_d;
                        if (win_q == WIN_LAST) begin
                            state_q  <= ST_REPORT;
                            busy_q   <= 1'b0;
                            tcm_a_q  <= cnt_a_d;
                            tcm_b_q  <= cnt_b_d;
                            tcm_c_q  <= cnt_c_d;
                            sector_q <= sector_d;
                            valid_q  <= 1'b1;
                        end else begin
                            win_q <= win_q + 1'b1;
                        end
                    end
                end
                ST_REPORT: begin
                    if (capture_enable_in) begin
                        state_q <= ST_MEASURE;
                        busy_q  <= 1'b1;
                        win_q   <= '0;
                        cnt_a_q <= '0;
                        cnt_b_q <= '0;
                        cnt_c_q <= '0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // A new overlap beats a simultaneous clear so a live fault is never lost.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else if (overlap) begin
            fault_q <= 1'b1;
        end else if (fault_clear_in) begin
            fault_q <= 1'b0;
        end
    end

    assign tcm_a_out               = tcm_a_q;
    assign tcm_b_out               = tcm_b_q;
    assign tcm_c_out               = tcm_c_q;
    assign sector_out              = sector_q;
    assign capture_valid_out       = valid_q;
    assign shoot_through_fault_out = fault_q;
    assign busy_out                = busy_q;

endmodule

// File: tb/tb_svpwm_gate_capture_module.sv
// Directed bench for svpwm_gate_capture_module with a 100-cycle window; expected
// reports are queued as each window is driven and compared when the valid pulse appears.
module tb_svpwm_gate_capture_module;

    localparam int DW  = 16;
    localparam int WIN = 100;

    logic          sys_clk = 1'b0;
    logic          reset;
    logic          capture_enable_in;
    logic          fault_clear_in;
    logic          a_hi, a_lo, b_hi, b_lo, c_hi, c_lo;
    logic [DW-1:0] tcm_a_out, tcm_b_out, tcm_c_out;
    logic [2:0]    sector_out;
    logic          capture_valid_out;
    logic          shoot_through_fault_out;
    logic          busy_out;

    typedef struct {
        int a;
        int b;
        int c;
        int s;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    svpwm_gate_capture_module #(
        .DATA_WIDTH   (DW),
        .WINDOW_CYCLES(WIN)
    ) dut (
        .sys_clk                (sys_clk),
        .reset                  (reset),
        .capture_enable_in      (capture_enable_in),
        .fault_clear_in         (fault_clear_in),
        .phase_a_high_side_in   (a_hi),
        .phase_a_low_side_in    (a_lo),
        .phase_b_high_side_in   (b_hi),
        .phase_b_low_side_in    (b_lo),
        .phase_c_high_side_in   (c_hi),
        .phase_c_low_side_in    (c_lo),
        .tcm_a_out              (tcm_a_out),
        .tcm_b_out              (tcm_b_out),
        .tcm_c_out              (tcm_c_out),
        .sector_out             (sector_out),
        .capture_valid_out      (capture_valid_out),
        .shoot_through_fault_out(shoot_through_fault_out),
        .busy_out               (busy_out)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_outputs(input string tag, input int ea, input int eb, input int ec,
                                 input int es, input int ev, input int ef, input int eby);
        check({tag, ".tcm_a"}, 32'(tcm_a_out), ea);
        check({tag, ".tcm_b"}, 32'(tcm_b_out), eb);
        check({tag, ".tcm_c"}, 32'(tcm_c_out), ec);
        check({tag, ".sector"}, 32'(sector_out), es);
        check({tag, ".valid"}, 32'(capture_valid_out), ev);
        check({tag, ".fault"}, 32'(shoot_through_fault_out), ef);
        check({tag, ".busy"}, 32'(busy_out), eby);
    endtask

    // Entered at the falling edge just after the DUT moved into MEASURE (t=0);
    // leaves at t=0 of the following window. High sides run from t=5 for n cycles.
    task automatic run_window(input int na, input int nb, input int nc, input int es);
        exp_t e;
        e.a = na; e.b = nb; e.c = nc; e.s = es;
        exp_q.push_back(e);
        for (int t = 0; t <= WIN; t++) begin
            a_hi = (t >= 5) && (t < 5 + na);
            b_hi = (t >= 5) && (t < 5 + nb);
            c_hi = (t >= 5) && (t < 5 + nc);
            check("win.busy", 32'(busy_out), 32'(t != WIN));
            check("win.valid", 32'(capture_valid_out), 32'(t == WIN));
            @(negedge sys_clk);
        end
    endtask

    // Scoreboard: each valid pulse must match the oldest queued window.
    always @(negedge sys_clk) begin
        if (!reset && capture_valid_out) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL sb.unexpected_valid: observed pulse expected none");
            end
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb.tcm_a", 32'(tcm_a_out), e.a);
                check("sb.tcm_b", 32'(tcm_b_out), e.b);
                check("sb.tcm_c", 32'(tcm_c_out), e.c);
                check("sb.sector", 32'(sector_out), e.s);
            end
        end
    end

    initial begin
        reset = 1'b1;
        capture_enable_in = 1'b0;
        fault_clear_in = 1'b0;
        {a_hi, a_lo, b_hi, b_lo, c_hi, c_lo} = '0;
        repeat (3) @(negedge sys_clk);
        check_outputs("reset", 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        repeat (2) @(negedge sys_clk);
        check("idle.busy", 32'(busy_out), 0);

        // Back-to-back windows with enable held high
        capture_enable_in = 1'b1;
        @(negedge sys_clk);
        run_window(60, 40, 20, 3);
        run_window(50, 70, 10, 1);
        run_window(10, 30, 80, 4);
        run_window(50, 50, 50, 3);

        // Abort: enable drops at window cycle 50
        for (int t = 0; t < 50; t++) begin
            a_hi = (t >= 5);
            @(negedge sys_clk);
        end
        capture_enable_in = 1'b0;
        a_hi = 1'b0;
        @(negedge sys_clk);
        check_outputs("abort", 50, 50, 50, 3, 0, 0, 0);
        repeat (150) @(negedge sys_clk);
        check_outputs("abort_late", 50, 50, 50, 3, 0, 0, 0);

        // Shoot-through on phase B for 3 cycles
        b_hi = 1'b1; b_lo = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk);
        check("fault.not_yet", 32'(shoot_through_fault_out), 0);
        @(negedge sys_clk);
        b_hi = 1'b0; b_lo = 1'b0;
        check("fault.set", 32'(shoot_through_fault_out), 1);
        repeat (10) @(negedge sys_clk);
        check("fault.sticky", 32'(shoot_through_fault_out), 1);
        fault_clear_in = 1'b1;
        @(negedge sys_clk);
        fault_clear_in = 1'b0;
        check("fault.cleared", 32'(shoot_through_fault_out), 0);
        repeat (3) @(negedge sys_clk);
        check("fault.stays_clear", 32'(shoot_through_fault_out), 0);

        // Clear coincides with the first cycle the new overlap is seen
        c_hi = 1'b1; c_lo = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk);
        fault_clear_in = 1'b1;
        @(negedge sys_clk);
        fault_clear_in = 1'b0;
        c_hi = 1'b0; c_lo = 1'b0;
        check("fault.set_wins", 32'(shoot_through_fault_out), 1);
        repeat (5) @(negedge sys_clk);
        check("fault.set_wins_hold", 32'(shoot_through_fault_out), 1);
        fault_clear_in = 1'b1;
        @(negedge sys_clk);
        fault_clear_in = 1'b0;
        check("fault.cleared2", 32'(shoot_through_fault_out), 0);

        // Reset at window cycle 30
        capture_enable_in = 1'b1;
        @(negedge sys_clk);
        check("rst_win.busy", 32'(busy_out), 1);
        for (int t = 0; t < 30; t++) begin
            a_hi = (t >= 5);
            @(negedge sys_clk);
        end
        reset = 1'b1;
        a_hi = 1'b0;
        #1;
        check_outputs("mid_reset", 0, 0, 0, 0, 0, 0, 0);
        @(negedge sys_clk);
        check_outputs("held_reset", 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        @(negedge sys_clk);
        run_window(40, 60, 0, 1);
        capture_enable_in = 1'b0;
        repeat (5) @(negedge sys_clk);
        check("end.busy", 32'(busy_out), 0);

        check("sb.pending", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/svpwm_gate_capture_module.md
SVPWM_GATE_CAPTURE_MODULE -- requirements
Module: svpwm_gate_capture_module

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of the duty-count outputs.
REQ-002 Parameter WINDOW_CYCLES, default 4000: length of the measurement window in sys_clk cycles, range 2..2^DATA_WIDTH-1.
REQ-003 sys_clk  input  1  single system clock; all flops on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 capture_enable_in  input  1  level; high = run back-to-back measurement windows.
REQ-006 fault_clear_in  input  1  one-cycle pulse that clears the sticky fault.
REQ-007 phase_a_high_side_in, phase_a_low_side_in, phase_b_high_side_in, phase_b_low_side_in, phase_c_high_side_in, phase_c_low_side_in  input  1 each  asynchronous gate drive signals from the SVPWM generator.
REQ-008 tcm_a_out, tcm_b_out, tcm_c_out  output  DATA_WIDTH each  unsigned high-side on-time of each phase, in cycles, for the last completed window.
REQ-009 sector_out  output  3  sector code N (1..6) decoded from the duty ordering; 0 = none.
REQ-010 capture_valid_out  output  1  one-cycle pulse; tcm_*/sector_out updated.
REQ-011 shoot_through_fault_out  output  1  sticky fault flag for high and low side of one phase on together.
REQ-012 busy_out  output  1  high while a window is being measured.

Function
REQ-013 Each of the six gate inputs SHALL pass through a 2-flop synchronizer; all counting and fault checks SHALL use the synchronized samples.
REQ-014 The FSM SHALL have states IDLE, MEASURE and REPORT; reset SHALL enter IDLE.
REQ-015 IDLE -> MEASURE on the first cycle capture_enable_in=1; entry SHALL clear the window counter and the three phase counters.
REQ-016 In MEASURE, each phase counter SHALL increment on every cycle its synchronized high side is 1, saturating at 2^DATA_WIDTH-1.
REQ-017 MEASURE SHALL last exactly WINDOW_CYCLES cycles and then go to REPORT.
REQ-018 REPORT (one cycle) SHALL load tcm_a/b/c_out from the counters, load sector_out, and assert capture_valid_out for that cycle only.
REQ-019 REPORT -> MEASURE with cleared counters if capture_enable_in=1; otherwise REPORT -> IDLE.
REQ-020 capture_enable_in=0 during MEASURE SHALL abort the window: go to IDLE next cycle, no valid pulse, outputs keep their previous values.
REQ-021 busy_out SHALL be 1 exactly in MEASURE.
REQ-022 Sector decode uses counts a, b, c; the first matching rule wins: a>=b>=c -> 3; b>=a>=c -> 1; b>=c>=a -> 5; c>=b>=a -> 4; c>=a>=b -> 6; a>=c>=b -> 2.
REQ-023 shoot_through_fault_out SHALL set one cycle after any synchronized phase has high and low side both 1, in any state, and SHALL hold until fault_clear_in or reset.
REQ-024 If fault_clear_in and a new shoot-through occur in the same cycle, the set SHALL win.

Reset
REQ-025 On reset, all outputs SHALL be 0 (tcm_* = 0, sector_out = 0, capture_valid_out = 0, shoot_through_fault_out = 0, busy_out = 0).
REQ-026 On reset, the synchronizers and counters SHALL clear and the FSM SHALL go to IDLE.
REQ-027 Reset asserted during MEASURE SHALL discard the window with no valid pulse.

Verification (WINDOW_CYCLES=100)
REQ-028 Enable held high; A, B, C high sides high for 60, 40 and 20 cycles of each window -> capture_valid_out pulses every 101 cycles; tcm = 60/40/20; sector_out = 3.
REQ-029 A=50, B=70, C=10 -> sector_out = 1; A=10, B=30, C=80 -> sector_out = 4.
REQ-030 A=B=C=50 -> tcm = 50/50/50; sector_out = 3 (tie priority).
REQ-031 phase_b high and low sides both 1 for 3 cycles -> fault = 1 and stays 1; fault_clear_in pulse -> fault = 0; clear in the same cycle as a new overlap -> fault stays 1.
REQ-032 capture_enable_in drops at window cycle 50 -> busy_out = 0 next cycle, no valid pulse, tcm_* unchanged.
REQ-033 reset pulse at window cycle 30 -> all outputs 0 immediately; FSM in IDLE; first valid pulse comes a full window after enable is seen again.
